// File: rtl/ts_ddr_arbiter.sv
// Shares one Avalon-MM DDR3 master port between the TS record (write) and replay (read) paths.
// Burst-limited round-robin arbitration with a cap on reads in flight.
module ts_ddr_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned MAX_PENDING = 8,
  localparam int unsigned PW = $clog2(MAX_PENDING + 1)
) (
  input  logic                  SYS_CLOCK,
  input  logic                  SYS_RESET,
  input  logic                  WR_REQ,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [3:0]            WR_BE,
  output logic                  WR_ACK,
  input  logic                  RD_REQ,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  RD_ACK,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic [ADDR_WIDTH-1:0] ddr_address,
  output logic                  ddr_write,
  output logic [DATA_WIDTH-1:0] ddr_writedata,
  output logic [3:0]            ddr_byteenable,
  output logic                  ddr_read,
  input  logic                  ddr_waitrequest,
  input  logic                  ddr_readdatavalid,
  input  logic [DATA_WIDTH-1:0] ddr_readdata,
  output logic [1:0]            GRANT,
  output logic [PW-1:0]         PENDING
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] GNT_WR = 2'b01;
  localparam logic [1:0] GNT_RD = 2'b10;

  typedef enum logic [1:0] {ST_ARB, ST_ISSUE_WR, ST_ISSUE_RD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic [1:0]            grant_q, grant_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [PW-1:0]         pending_q, pending_d;

  logic wr_accept, rd_accept, wr_elig, rd_elig, burst_lt_max;
  logic grant_wr, grant_rd;
  logic [BW-1:0] burst_inc;

  assign wr_accept    = write_q && !ddr_waitrequest;
  assign rd_accept    = read_q && !ddr_waitrequest;
  assign wr_elig      = WR_REQ;
  assign rd_elig      = RD_REQ && (pending_q < PW'(MAX_PENDING));
  assign burst_lt_max = burst_q < BW'(MAX_BURST);
  assign burst_inc    = burst_lt_max ? burst_q + BW'(1) : burst_q;

  // Winner selection: previous owner keeps the port until its burst allowance runs out
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wr_elig && rd_elig) begin
      grant_rd = grant_q[1] ? burst_lt_max : !burst_lt_max;
      grant_wr = !grant_rd;
    end else begin
      grant_wr = wr_elig;
      grant_rd = rd_elig;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    write_d   = write_q;
    read_d    = read_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    pending_d = pending_q;

    case (state_q)
      ST_ARB: begin
        if (grant_wr) begin
          state_d = ST_ISSUE_WR;
          write_d = 1'b1;
          addr_d  = WR_ADDR;
          wdata_d = WR_DATA;
          be_d    = WR_BE;
          grant_d = GNT_WR;
          burst_d = (grant_q == GNT_WR) ? burst_inc : BW'(1);
        end else if (grant_rd) begin
          state_d = ST_ISSUE_RD;
          read_d  = 1'b1;
          addr_d  = RD_ADDR;
          be_d    = 4'hF;
          grant_d = GNT_RD;
          burst_d = (grant_q == GNT_RD) ? burst_inc : BW'(1);
        end
      end
      ST_ISSUE_WR: begin
        if (!ddr_waitrequest) begin
          write_d = 1'b0;
          state_d = ST_ARB;
        end
      end
      ST_ISSUE_RD: begin
        if (!ddr_waitrequest) begin
          read_d  = 1'b0;
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
        write_d = 1'b0;
        read_d  = 1'b0;
      end
    endcase

    // A return with nothing outstanding is forwarded but never underflows the count
    case ({rd_accept, ddr_readdatavalid && (pending_q != '0)})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      state_q   <= ST_ARB;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 4'hF;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      grant_q   <= '0;
      burst_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      write_q   <= write_d;
      read_q    <= read_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
      pending_q <= pending_d;
    end
  end

  assign WR_ACK         = wr_accept && !SYS_RESET;
  assign RD_ACK         = rd_accept && !SYS_RESET;
  assign RD_DATA        = ddr_readdata;
  assign RD_VALID       = ddr_readdatavalid;
  assign ddr_address    = addr_q;
  assign ddr_write      = write_q;
  assign ddr_writedata  = wdata_q;
  assign ddr_byteenable = be_q;
  assign ddr_read       = read_q;
  assign GRANT          = grant_q;
  assign PENDING        = pending_q;

endmodule

// File: tb/tb_ts_ddr_arbiter.sv
// Bench for ts_ddr_arbiter: per-cycle vector table plus directed multi-cycle sequences.
module tb_ts_ddr_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req, wr_ack, rd_ack, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr, ddr_address;
  logic [DW-1:0] wr_data, rd_data, ddr_writedata, ddr_readdata;
  logic [3:0]    wr_be, ddr_byteenable;
  logic          ddr_write, ddr_read, ddr_waitrequest, ddr_readdatavalid;
  logic [1:0]    grant;
  logic [PW-1:0] pending;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ts_ddr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16), .MAX_PENDING(8)) dut (
    .SYS_CLOCK(clk), .SYS_RESET(rst),
    .WR_REQ(wr_req), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_BE(wr_be), .WR_ACK(wr_ack),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_ACK(rd_ack), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .ddr_address(ddr_address), .ddr_write(ddr_write), .ddr_writedata(ddr_writedata),
    .ddr_byteenable(ddr_byteenable), .ddr_read(ddr_read), .ddr_waitrequest(ddr_waitrequest),
    .ddr_readdatavalid(ddr_readdatavalid), .ddr_readdata(ddr_readdata),
    .GRANT(grant), .PENDING(pending)
  );

  typedef struct {
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wait_r;
    logic          rdv;
    logic [DW-1:0] rdata;
    logic          e_write;
    logic          e_read;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [3:0]    e_be;
    logic          e_wack;
    logic          e_rack;
    logic          e_rvalid;
    logic [1:0]    e_grant;
    logic [PW-1:0] e_pend;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_idle();
    wr_req = 0; wr_addr = '0; wr_data = '0; wr_be = 4'hF;
    rd_req = 0; rd_addr = '0;
    ddr_waitrequest = 0; ddr_readdatavalid = 0; ddr_readdata = '0;
  endtask

  task automatic do_reset(input bit check_vals);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_vals) begin
      chk("rst_write", 64'(ddr_write), 64'd0);
      chk("rst_read", 64'(ddr_read), 64'd0);
      chk("rst_addr", 64'(ddr_address), 64'd0);
      chk("rst_wdata", 64'(ddr_writedata), 64'd0);
      chk("rst_be", 64'(ddr_byteenable), 64'hF);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_acks", 64'({wr_ack, rd_ack}), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int ncmd, acks, got;
    bit prev_rack, hit, rd_seen;
    logic [1:0] exp_g;

    // wr_req addr data be | rd_req addr | wait rdv rdata || write read addr wdata be wack rack rvalid grant pend
    tbl[0]  = '{1, 0, 32'hA0, 4'hF, 0, 0,    0, 0, 0,     0, 0, 0,    0,     4'hF, 0, 0, 0, 2'b00, 0};
    tbl[1]  = '{1, 0, 32'hA0, 4'hF, 0, 0,    0, 0, 0,     1, 0, 0,    32'hA0, 4'hF, 1, 0, 0, 2'b01, 0};
    tbl[2]  = '{1, 1, 32'hA1, 4'hF, 0, 0,    0, 0, 0,     0, 0, 0,    32'hA0, 4'hF, 0, 0, 0, 2'b01, 0};
    tbl[3]  = '{1, 1, 32'hA1, 4'hF, 0, 0,    0, 0, 0,     1, 0, 1,    32'hA1, 4'hF, 1, 0, 0, 2'b01, 0};
    tbl[4]  = '{1, 2, 32'hA2, 4'hF, 0, 0,    0, 0, 0,     0, 0, 1,    32'hA1, 4'hF, 0, 0, 0, 2'b01, 0};
    tbl[5]  = '{1, 2, 32'hA2, 4'hF, 0, 0,    0, 0, 0,     1, 0, 2,    32'hA2, 4'hF, 1, 0, 0, 2'b01, 0};
    tbl[6]  = '{1, 3, 32'hA3, 4'hF, 0, 0,    0, 0, 0,     0, 0, 2,    32'hA2, 4'hF, 0, 0, 0, 2'b01, 0};
    tbl[7]  = '{1, 3, 32'hA3, 4'hF, 0, 0,    0, 0, 0,     1, 0, 3,    32'hA3, 4'hF, 1, 0, 0, 2'b01, 0};
    tbl[8]  = '{1, 'h10, 32'hB0, 4'h3, 0, 0, 0, 0, 0,     0, 0, 3,    32'hA3, 4'hF, 0, 0, 0, 2'b01, 0};
    tbl[9]  = '{1, 'h10, 32'hB0, 4'h3, 0, 0, 1, 0, 0,     1, 0, 'h10, 32'hB0, 4'h3, 0, 0, 0, 2'b01, 0};
    tbl[10] = '{1, 'h10, 32'hB0, 4'h3, 0, 0, 1, 0, 0,     1, 0, 'h10, 32'hB0, 4'h3, 0, 0, 0, 2'b01, 0};
    tbl[11] = '{1, 'h10, 32'hB0, 4'h3, 0, 0, 1, 0, 0,     1, 0, 'h10, 32'hB0, 4'h3, 0, 0, 0, 2'b01, 0};
    tbl[12] = '{1, 'h10, 32'hB0, 4'h3, 0, 0, 0, 0, 0,     1, 0, 'h10, 32'hB0, 4'h3, 1, 0, 0, 2'b01, 0};
    tbl[13] = '{0, 0, 0, 4'hF, 1, 'h20,      0, 0, 0,     0, 0, 'h10, 32'hB0, 4'h3, 0, 0, 0, 2'b01, 0};
    tbl[14] = '{0, 0, 0, 4'hF, 1, 'h20,      0, 0, 0,     0, 1, 'h20, 32'hB0, 4'hF, 0, 1, 0, 2'b10, 0};
    tbl[15] = '{0, 0, 0, 4'hF, 0, 0,         0, 1, 32'hC0, 0, 0, 'h20, 32'hB0, 4'hF, 0, 0, 1, 2'b10, 1};
    tbl[16] = '{0, 0, 0, 4'hF, 0, 0,         0, 1, 32'hC1, 0, 0, 'h20, 32'hB0, 4'hF, 0, 0, 1, 2'b10, 0};
    tbl[17] = '{0, 0, 0, 4'hF, 0, 0,         0, 0, 0,     0, 0, 'h20, 32'hB0, 4'hF, 0, 0, 0, 2'b10, 0};

    do_reset(1'b1);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      wr_req = tbl[i].wr_req; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data; wr_be = tbl[i].wr_be;
      rd_req = tbl[i].rd_req; rd_addr = tbl[i].rd_addr;
      ddr_waitrequest = tbl[i].wait_r; ddr_readdatavalid = tbl[i].rdv; ddr_readdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_write", i), 64'(ddr_write), 64'(tbl[i].e_write));
      chk($sformatf("v%0d_read", i), 64'(ddr_read), 64'(tbl[i].e_read));
      chk($sformatf("v%0d_addr", i), 64'(ddr_address), 64'(tbl[i].e_addr));
      chk($sformatf("v%0d_wdata", i), 64'(ddr_writedata), 64'(tbl[i].e_wdata));
      chk($sformatf("v%0d_be", i), 64'(ddr_byteenable), 64'(tbl[i].e_be));
      chk($sformatf("v%0d_wack", i), 64'(wr_ack), 64'(tbl[i].e_wack));
      chk($sformatf("v%0d_rack", i), 64'(rd_ack), 64'(tbl[i].e_rack));
      chk($sformatf("v%0d_rvalid", i), 64'(rd_valid), 64'(tbl[i].e_rvalid));
      chk($sformatf("v%0d_grant", i), 64'(grant), 64'(tbl[i].e_grant));
      chk($sformatf("v%0d_pend", i), 64'(pending), 64'(tbl[i].e_pend));
      if (tbl[i].e_rvalid) chk($sformatf("v%0d_rdata", i), 64'(rd_data), 64'(tbl[i].rdata));
    end

    // Both requesters always busy: 16 writes, 16 reads, repeating; data returned one cycle after each read
    do_reset(1'b0);
    wr_req = 1; wr_addr = 'h100; wr_data = 32'hDEAD; rd_req = 1; rd_addr = 'h200;
    ncmd = 0; prev_rack = 0;
    for (int cyc = 0; cyc < 400 && ncmd < 64; cyc++) begin
      @(negedge clk);
      if (ddr_write || ddr_read) begin
        exp_g = ((ncmd / 16) % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("burst%0d_grant", ncmd), 64'(grant), 64'(exp_g));
        chk($sformatf("burst%0d_strobes", ncmd), 64'({ddr_read, ddr_write}), 64'(exp_g));
        ncmd++;
      end
      prev_rack = rd_ack;
      @(posedge clk); #1;
      ddr_readdatavalid = prev_rack;
    end
    chk("burst_cmd_count", 64'(ncmd), 64'd64);
    wr_req = 0; rd_req = 0; ddr_readdatavalid = 0;

    // Read cap: 8 accepted with nothing returned, then one return frees exactly one slot
    do_reset(1'b0);
    rd_req = 1; rd_addr = 'h300;
    acks = 0;
    for (int cyc = 0; cyc < 100 && acks < 8; cyc++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      @(posedge clk); #1;
    end
    rd_seen = 0;
    repeat (4) begin
      @(negedge clk);
      rd_seen |= ddr_read | rd_ack;
      @(posedge clk); #1;
    end
    chk("cap_acks", 64'(acks), 64'd8);
    chk("cap_pending", 64'(pending), 64'd8);
    chk("cap_read_low", 64'(rd_seen), 64'd0);
    ddr_readdatavalid = 1;
    @(posedge clk); #1;
    ddr_readdatavalid = 0;
    @(negedge clk);
    chk("cap_pending_after_ret", 64'(pending), 64'd7);
    got = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_ack) got++;
      @(posedge clk); #1;
    end
    chk("cap_one_more", 64'(got), 64'd1);
    chk("cap_pending_refill", 64'(pending), 64'd8);
    rd_req = 0;

    // Return coinciding with an acceptance at PENDING=3 leaves the count unchanged
    do_reset(1'b0);
    rd_req = 1; rd_addr = 'h400;
    hit = 0;
    for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
      @(posedge clk); #1;
      ddr_readdatavalid = (ddr_read && pending == 3);
      @(negedge clk);
      if (ddr_readdatavalid) begin
        chk("coin_rack", 64'(rd_ack), 64'd1);
        chk("coin_rvalid", 64'(rd_valid), 64'd1);
        hit = 1;
      end
    end
    chk("coin_reached", 64'(hit), 64'd1);
    @(posedge clk); #1;
    rd_req = 0; ddr_readdatavalid = 0;
    @(negedge clk);
    chk("coin_pending", 64'(pending), 64'd3);

    // Reset while a write is stalled: strobe, grant and count all clear, no acknowledge
    do_reset(1'b0);
    rd_req = 1; rd_addr = 'h500;
    got = 0;
    for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
      @(negedge clk);
      if (rd_ack) got = 1;
      @(posedge clk); #1;
    end
    chk("mid_read_acked", 64'(got), 64'd1);
    rd_req = 0;
    wr_req = 1; wr_addr = 'h600; wr_data = 32'h1234; ddr_waitrequest = 1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
      @(negedge clk);
      if (ddr_write) got = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("mid_write_up", 64'(got), 64'd1);
    chk("mid_pending_pre", 64'(pending), 64'd1);
    @(posedge clk); #1;
    rst = 1; ddr_readdatavalid = 1; ddr_readdata = 32'h77;
    @(negedge clk);
    chk("mid_no_wack", 64'(wr_ack), 64'd0);
    chk("mid_rvalid", 64'(rd_valid), 64'd1);
    chk("mid_rdata", 64'(rd_data), 64'h77);
    @(posedge clk); #1;
    rst = 0; wr_req = 0; ddr_waitrequest = 0; ddr_readdatavalid = 0;
    @(negedge clk);
    chk("mid_write_dropped", 64'(ddr_write), 64'd0);
    chk("mid_grant", 64'(grant), 64'd0);
    chk("mid_pending", 64'(pending), 64'd0);
    chk("mid_wack", 64'(wr_ack), 64'd0);
    @(posedge clk); #1;
    wr_req = 1; wr_addr = 'h5; wr_data = 32'h55;
    @(negedge clk);
    chk("post_arb_idle", 64'(ddr_write), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_write", 64'(ddr_write), 64'd1);
    chk("post_wack", 64'(wr_ack), 64'd1);
    chk("post_addr", 64'(ddr_address), 64'h5);
    @(posedge clk); #1;
    wr_req = 0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ts_ddr_arbiter.md
# ts_ddr_arbiter

Shares the single 32-bit Avalon-MM DDR3 master port between the record path (word writer) and the replay path (word reader) of the TS recorder. Sits between the TS state machine's packing/unpacking logic and the DDR3 controller in the SYS_CLOCK (50 MHz) domain. Uses burst-limited round-robin arbitration and limits in-flight reads so read data is never lost.

## Interface
Parameters:
- ADDR_WIDTH, 24, word address width
- DATA_WIDTH, 32, data word width
- MAX_BURST, 16, max consecutive grants to one requester while the other waits (≥1)
- MAX_PENDING, 8, max accepted-but-unreturned reads (≥1); PENDING width PW = clog2(MAX_PENDING+1)

Ports:
- SYS_CLOCK  in  1  50 MHz clock; all logic on its rising edge
- SYS_RESET  in  1  reset, synchronous, active-high
- WR_REQ  in  1  write requester has a word; held with WR_ADDR/WR_DATA/WR_BE until WR_ACK
- WR_ADDR  in  ADDR_WIDTH  write word address
- WR_DATA  in  DATA_WIDTH  write data
- WR_BE  in  4  write byte enables
- WR_ACK  out  1  one-cycle pulse: word accepted by DDR
- RD_REQ  in  1  read requester wants a word; held with RD_ADDR until RD_ACK
- RD_ADDR  in  ADDR_WIDTH  read word address
- RD_ACK  out  1  one-cycle pulse: read command accepted by DDR
- RD_DATA  out  DATA_WIDTH  returned read data
- RD_VALID  out  1  RD_DATA valid this cycle
- ddr_address  out  ADDR_WIDTH  DDR command address
- ddr_write  out  1  DDR write strobe
- ddr_writedata  out  DATA_WIDTH  DDR write data
- ddr_byteenable  out  4  DDR byte enables
- ddr_read  out  1  DDR read strobe
- ddr_waitrequest  in  1  command stalled while high
- ddr_readdatavalid  in  1  read data returning
- ddr_readdata  in  DATA_WIDTH  read data
- GRANT  out  2  {read, write} owner of current/last command, one-hot or 0
- PENDING  out  PW  reads in flight

## Operation
- States: ARB, ISSUE_WR, ISSUE_RD. Reset → ARB.
- ARB: eligible writer = WR_REQ; eligible reader = RD_REQ && PENDING < MAX_PENDING (registered count).
  - Only one eligible → grant it.
  - Both eligible: keep last owner if burst_cnt < MAX_BURST, else grant the other.
  - On grant, latch address/data/byteenable into ddr_* registers, set GRANT, go to ISSUE_WR/ISSUE_RD. None eligible → stay, strobes low, GRANT holds last value.
- burst_cnt: reset to 1 on grant to a different owner, increment (saturating at MAX_BURST) on grant to the same owner.
- ISSUE_x: strobe high, fields stable. Accepted when strobe && !ddr_waitrequest; WR_ACK/RD_ACK = that condition (combinational), next state ARB with strobe low. Waitrequest high → hold everything.
- ddr_byteenable in a read command = 4'hF; ddr_writedata unchanged.
- PENDING: +1 on read acceptance, −1 on ddr_readdatavalid, unchanged if both same cycle. A readdatavalid at PENDING = 0 does not underflow (stays 0); data is still forwarded.
- RD_DATA = ddr_readdata, RD_VALID = ddr_readdatavalid (combinational pass-through, in order).
- ddr_write and ddr_read are never high together.

## Timing
- Reset values: ddr_write 0, ddr_read 0, ddr_address 0, ddr_writedata 0, ddr_byteenable 4'hF, GRANT 0, PENDING 0, WR_ACK 0, RD_ACK 0, burst_cnt 0. Reset mid-command drops the strobe on the next edge; PENDING cleared; returned data after reset is still passed to RD_VALID.
- Request visible in ARB cycle N → strobe high in N+1 → accepted at earliest in N+1 (ACK in N+1) → ARB in N+2. Minimum 2 cycles per word; each waitrequest cycle adds 1.
- Requester may change REQ/fields only after the edge that ends its ACK cycle. ARB samples the updated value.
- Read latency is set by DDR; RD_VALID has 0 added latency.

## Test plan
- Write only, waitrequest 0, 4 words addr 0..3 → ddr_write high in cycles 1,3,5,7 after WR_REQ, WR_ACK in the same cycles, addresses 0,1,2,3.
- Waitrequest held 3 cycles on first write → ddr_write, address and data stable for 4 cycles, single WR_ACK on the 4th.
- Both requesting continuously, MAX_BURST=16 → GRANT sequence of 16 writes then 16 reads repeating (order starts with first granted), no strobe overlap.
- Read only, MAX_PENDING=8, readdatavalid withheld → 8 RD_ACKs, PENDING=8, ddr_read stays low; one readdatavalid → PENDING=7, one more read issued.
- readdatavalid coincident with read acceptance at PENDING=3 → PENDING stays 3; spurious readdatavalid at 0 → PENDING 0, RD_VALID 1.
- SYS_RESET asserted while ddr_write high under waitrequest → next edge: ddr_write 0, GRANT 0, PENDING 0, state ARB; no WR_ACK.
